// File: rtl/edge_trig_seq.sv
// edge_trig_seq
//   Sequencer for the moving-sum edge-trigger datapath (ADC clock domain).
//   Drives the mov_sum core reset/start and holds off triggers until the sum
//   window has filled. It also qualifies raw edge-trigger pulses with a
//   holdoff, one-shot/continuous mode and an optional arm timeout.
//
//   Optional feature: define EDGE_SEQ_TIMEOUT_EN to enable the ARMED timeout.
//   Without it, timeout_i is unused and timed_out_o is tied to 0.
//
// Ports
//   clk           ADC clock, rising edge
//   reset_n       asynchronous active-low reset
//   arm_i         pulse: start a sequence (from IDLE or DONE)
//   disarm_i      pulse: abort to IDLE (highest priority)
//   continuous_i  1 = re-arm after holdoff, 0 = one-shot
//   window_i      moving-sum window length, sampled on FILL entry
//   holdoff_i     suppressed cycles after a trigger (live)
//   timeout_i     ARMED cycle budget, 0 = none (timeout build only)
//   sum_val_i     core sum-valid strobe
//   raw_trig_i    unqualified trigger from the edge detector
//   core_rst_o    reset to mov_sum core
//   core_start_o  start to mov_sum core
//   trig_o        qualified trigger, 1-cycle pulse
//   armed_o       high in ARMED
//   busy_o        high in CRST/FILL/ARMED/HOLDOFF
//   timed_out_o   sticky timeout flag, cleared by arm_i
//   trig_cnt_o    qualified triggers since last arm, saturating
module edge_trig_seq #(
  parameter int RST_CYCLES = 4,
  parameter int HOLDOFF_W  = 16,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 arm_i,
  input  logic                 disarm_i,
  input  logic                 continuous_i,
  input  logic [7:0]           window_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 sum_val_i,
  input  logic                 raw_trig_i,
  output logic                 core_rst_o,
  output logic                 core_start_o,
  output logic                 trig_o,
  output logic                 armed_o,
  output logic                 busy_o,
  output logic                 timed_out_o,
  output logic [CNT_W-1:0]     trig_cnt_o
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, CRST, FILL, ARMED, HOLDOFF, DONE} state_t;

  state_t               state_reg, state_next;
  logic [RST_W-1:0]     rst_cnt_reg, rst_cnt_next;
  logic [7:0]           window_reg, window_next;
  logic [7:0]           fill_cnt_reg, fill_cnt_next;
  logic [HOLDOFF_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [CNT_W-1:0]     trig_cnt_reg, trig_cnt_next;
  logic                 trig_reg, trig_next;
  logic                 core_rst_reg, core_rst_next;
  logic                 core_start_reg, core_start_next;
  logic                 armed_reg, armed_next;
  logic                 busy_reg, busy_next;

`ifdef EDGE_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic                 timed_out_reg, timed_out_next;
`else
  logic                 unused_timeout;
  assign unused_timeout = ^timeout_i;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      rst_cnt_reg    <= '0;
      window_reg     <= '0;
      fill_cnt_reg   <= '0;
      hold_cnt_reg   <= '0;
      trig_cnt_reg   <= '0;
      trig_reg       <= 1'b0;
      core_rst_reg   <= 1'b0;
      core_start_reg <= 1'b0;
      armed_reg      <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef EDGE_SEQ_TIMEOUT_EN
      tmo_cnt_reg    <= '0;
      timed_out_reg  <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      rst_cnt_reg    <= rst_cnt_next;
      window_reg     <= window_next;
      fill_cnt_reg   <= fill_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      trig_cnt_reg   <= trig_cnt_next;
      trig_reg       <= trig_next;
      core_rst_reg   <= core_rst_next;
      core_start_reg <= core_start_next;
      armed_reg      <= armed_next;
      busy_reg       <= busy_next;
`ifdef EDGE_SEQ_TIMEOUT_EN
      tmo_cnt_reg    <= tmo_cnt_next;
      timed_out_reg  <= timed_out_next;
`endif
    end
  end

  // Per-state counters default to zero, so each one restarts whenever its
  // state is (re-)entered without explicit entry logic.
  always_comb begin
    state_next     = state_reg;
    rst_cnt_next   = '0;
    fill_cnt_next  = '0;
    hold_cnt_next  = '0;
    window_next    = window_reg;
    trig_cnt_next  = trig_cnt_reg;
    trig_next      = 1'b0;
`ifdef EDGE_SEQ_TIMEOUT_EN
    tmo_cnt_next   = '0;
    timed_out_next = timed_out_reg;
`endif

    case (state_reg)
      IDLE, DONE: begin
        if (arm_i) begin
          state_next    = CRST;
          trig_cnt_next = '0;
`ifdef EDGE_SEQ_TIMEOUT_EN
          timed_out_next = 1'b0;
`endif
        end
      end
      CRST: begin
        if (rst_cnt_reg == RST_W'(RST_CYCLES - 1)) begin
          state_next  = FILL;
          window_next = window_i;
        end else begin
          rst_cnt_next = rst_cnt_reg + RST_W'(1);
        end
      end
      FILL: begin
        if (window_reg == 8'd0) begin
          state_next = ARMED;
        end else if (sum_val_i) begin
          // fill_cnt stays below window_reg, so the increment cannot wrap
          if (fill_cnt_reg + 8'd1 == window_reg)
            state_next = ARMED;
          else
            fill_cnt_next = fill_cnt_reg + 8'd1;
        end else begin
          fill_cnt_next = fill_cnt_reg;
        end
      end
      ARMED: begin
        if (raw_trig_i) begin
          // a trigger on the timeout cycle wins over the timeout
          trig_next  = 1'b1;
          state_next = HOLDOFF;
          if (trig_cnt_reg != '1)
            trig_cnt_next = trig_cnt_reg + CNT_W'(1);
        end
`ifdef EDGE_SEQ_TIMEOUT_EN
        else if ((timeout_i != '0) && (tmo_cnt_reg + TIMEOUT_W'(1) == timeout_i)) begin
          state_next     = DONE;
          timed_out_next = 1'b1;
        end else if (tmo_cnt_reg != '1) begin
          tmo_cnt_next = tmo_cnt_reg + TIMEOUT_W'(1);
        end else begin
          tmo_cnt_next = tmo_cnt_reg;
        end
`endif
      end
      HOLDOFF: begin
        // HOLDOFF lasts holdoff_i+1 cycles (the trig_o cycle plus holdoff_i).
        // >= so a live reduction of holdoff_i never strands the counter.
        if (hold_cnt_reg >= holdoff_i)
          state_next = continuous_i ? ARMED : DONE;
        else
          hold_cnt_next = hold_cnt_reg + HOLDOFF_W'(1);
      end
      default: state_next = IDLE;
    endcase

    // disarm overrides everything, including a coincident trigger or arm
    if (disarm_i) begin
      state_next    = IDLE;
      trig_next     = 1'b0;
      trig_cnt_next = trig_cnt_reg;
`ifdef EDGE_SEQ_TIMEOUT_EN
      timed_out_next = timed_out_reg;
`endif
    end

    // outputs are registered from the next state so reset forces them all low
    core_rst_next   = (state_next == IDLE) || (state_next == CRST);
    core_start_next = (state_next == FILL) || (state_next == ARMED) ||
                      (state_next == HOLDOFF);
    armed_next      = (state_next == ARMED);
    busy_next       = core_start_next || (state_next == CRST);
  end

  assign core_rst_o   = core_rst_reg;
  assign core_start_o = core_start_reg;
  assign trig_o       = trig_reg;
  assign armed_o      = armed_reg;
  assign busy_o       = busy_reg;
  assign trig_cnt_o   = trig_cnt_reg;
`ifdef EDGE_SEQ_TIMEOUT_EN
  assign timed_out_o  = timed_out_reg;
`else
  assign timed_out_o  = 1'b0;
`endif

endmodule

// File: tb/tb_edge_trig_seq.sv
// tb_edge_trig_seq
//   Directed self-checking bench for edge_trig_seq. Inputs change and outputs
//   are checked on the falling clock edge; the DUT acts on the rising edge.
module tb_edge_trig_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm_i, disarm_i, continuous_i, sum_val_i, raw_trig_i;
  logic [7:0]  window_i;
  logic [15:0] holdoff_i;
  logic [31:0] timeout_i;
  logic        core_rst_o, core_start_o, trig_o, armed_o, busy_o, timed_out_o;
  logic [15:0] trig_cnt_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  edge_trig_seq #(
    .RST_CYCLES(4), .HOLDOFF_W(16), .CNT_W(16), .TIMEOUT_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .arm_i(arm_i), .disarm_i(disarm_i),
    .continuous_i(continuous_i), .window_i(window_i), .holdoff_i(holdoff_i),
    .timeout_i(timeout_i), .sum_val_i(sum_val_i), .raw_trig_i(raw_trig_i),
    .core_rst_o(core_rst_o), .core_start_o(core_start_o), .trig_o(trig_o),
    .armed_o(armed_o), .busy_o(busy_o), .timed_out_o(timed_out_o),
    .trig_cnt_o(trig_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // {core_rst, core_start, armed, busy}
  task automatic chk_st(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, core_rst_o, core_start_o, armed_o, busy_o}, {28'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // arm with window 0: 4 CRST cycles, 1 FILL cycle, then ARMED
  task automatic arm_fast();
    window_i = 8'd0;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; arm_i = 1'b0; disarm_i = 1'b0; continuous_i = 1'b0;
    sum_val_i = 1'b0; raw_trig_i = 1'b0; window_i = 8'd3;
    holdoff_i = 16'd10; timeout_i = 32'd0;

    #2;
    chk_st("reset_outputs", 4'b0000);
    chk("reset_trig", {31'd0, trig_o}, 32'd0);
    chk("reset_cnt", {16'd0, trig_cnt_o}, 32'd0);
    chk("reset_tmo", {31'd0, timed_out_o}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_st("idle", 4'b1000);

    // 1: arm, 4 CRST cycles, window of 3 strobes
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_st("crst", 4'b1001);
      tick();
    end
    chk_st("fill_entry", 4'b0101);
    for (int s = 1; s <= 3; s++) begin
      sum_val_i = 1'b1;
      tick();
      sum_val_i = 1'b0;
      if (s < 3) begin
        chk_st("fill_strobe", 4'b0101);
        tick();
        chk_st("fill_gap", 4'b0101);
      end
    end
    chk_st("armed_after_3", 4'b0111);
    $display("[TB] window fill done, armed=%0b", armed_o);

    // 2: one-shot, holdoff 10 -> HOLDOFF spans 11 cycles then DONE
    continuous_i = 1'b0;
    holdoff_i = 16'd10;
    raw_trig_i = 1'b1;
    tick();
    chk("oneshot_trig", {31'd0, trig_o}, 32'd1);
    chk("oneshot_cnt", {16'd0, trig_cnt_o}, 32'd1);
    chk_st("holdoff", 4'b0101);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("holdoff_no_trig", {31'd0, trig_o}, 32'd0);
      chk_st("holdoff_busy", 4'b0101);
    end
    tick();
    chk_st("done", 4'b0000);
    tick();
    chk("done_no_trig", {31'd0, trig_o}, 32'd0);
    chk("done_cnt_hold", {16'd0, trig_cnt_o}, 32'd1);
    raw_trig_i = 1'b0;
    $display("[TB] one-shot done, cnt=%0d", trig_cnt_o);

    // 3: continuous, holdoff 5, raw every cycle for 30 cycles (window 0)
    window_i = 8'd0;
    continuous_i = 1'b1;
    holdoff_i = 16'd5;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    chk("arm_clears_cnt", {16'd0, trig_cnt_o}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk_st("fill_w0", 4'b0101);
    tick();
    chk_st("armed_w0", 4'b0111);
    raw_trig_i = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk("cont_trig", {31'd0, trig_o}, {31'd0, ((k - 1) % 7) == 0});
    end
    chk("cont_cnt", {16'd0, trig_cnt_o}, 32'd5);
    $display("[TB] continuous holdoff5, cnt=%0d", trig_cnt_o);

    // holdoff 0: minimum trig_o spacing of 2
    raw_trig_i = 1'b0;
    holdoff_i = 16'd0;
    tick();
    chk_st("armed_h0", 4'b0111);
    raw_trig_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("h0_trig", {31'd0, trig_o}, {31'd0, (k % 2) == 1});
    end
    raw_trig_i = 1'b0;
    chk("h0_cnt", {16'd0, trig_cnt_o}, 32'd8);
    chk_st("h0_armed", 4'b0111);

    // 4: disarm coincident with raw trigger
    disarm_i = 1'b1;
    raw_trig_i = 1'b1;
    tick();
    disarm_i = 1'b0;
    raw_trig_i = 1'b0;
    chk("disarm_no_trig", {31'd0, trig_o}, 32'd0);
    chk("disarm_cnt", {16'd0, trig_cnt_o}, 32'd8);
    chk_st("disarm_idle", 4'b1000);

    // arm and disarm together: disarm wins, counter not cleared
    arm_i = 1'b1;
    disarm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    disarm_i = 1'b0;
    chk_st("arm_disarm_idle", 4'b1000);
    chk("arm_disarm_cnt", {16'd0, trig_cnt_o}, 32'd8);
    $display("[TB] disarm checks done");

    // 5: arm timeout of 100 cycles
    timeout_i = 32'd100;
    arm_fast();
    chk_st("tmo_armed", 4'b0111);
    for (int i = 1; i < 100; i++) tick();
`ifdef EDGE_SEQ_TIMEOUT_EN
    chk_st("tmo_armed_99", 4'b0111);
    chk("tmo_not_yet", {31'd0, timed_out_o}, 32'd0);
    tick();
    chk_st("tmo_done", 4'b0000);
    chk("tmo_set", {31'd0, timed_out_o}, 32'd1);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    chk("tmo_cleared", {31'd0, timed_out_o}, 32'd0);
`else
    tick();
    tick();
    chk_st("no_tmo_armed", 4'b0111);
    chk("no_tmo_flag", {31'd0, timed_out_o}, 32'd0);
`endif
    disarm_i = 1'b1;
    tick();
    disarm_i = 1'b0;
    timeout_i = 32'd0;
    $display("[TB] timeout checks done");

    // 6: async reset mid-HOLDOFF while trig_o is high
    continuous_i = 1'b0;
    holdoff_i = 16'd20;
    arm_fast();
    raw_trig_i = 1'b1;
    tick();
    raw_trig_i = 1'b0;
    chk("pre_rst_trig", {31'd0, trig_o}, 32'd1);
    chk("pre_rst_cnt", {16'd0, trig_cnt_o}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_st("async_rst_out", 4'b0000);
    chk("async_rst_trig", {31'd0, trig_o}, 32'd0);
    chk("async_rst_cnt", {16'd0, trig_cnt_o}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk_st("post_rst_idle", 4'b1000);
    chk("post_rst_cnt", {16'd0, trig_cnt_o}, 32'd0);
    $display("[TB] async reset checks done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
